// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | riscv_pkg : shared constants and fetch-stage state encoding        |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package riscv_pkg;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory request/response bus            |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : IF stage - PC, single-outstanding imem fetch, IF/ID   |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        PCWrite,
  input  wire logic        redirect_valid,
  input  wire logic [31:0] redirect_pc,
  fetch_unit_if.master     imem,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_plus_4,
  output logic [31:0]      if_instruction,
  output logic             if_valid
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n, pc_inc;
  logic [31:0]  word_n;
  logic         drop, drop_n;
  logic         valid_n;
  logic         consume;
  logic         accepted;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_inc   = pc + 32'd4;
  assign consume  = (state == VALID) && PCWrite;
  // A redirect always suppresses the request so the stale address never reaches memory.
  assign imem.imem_req  = !rst && !redirect_valid && ((state == FETCH) || consume);
  assign imem.imem_addr = (state == VALID) ? pc_inc : pc;
  assign accepted = imem.imem_req && imem.imem_ready;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    valid_n = if_valid;
    word_n  = if_instruction;
    if (redirect_valid) begin
      pc_n    = {redirect_pc[31:2], 2'b00};
      valid_n = 1'b0;
      word_n  = NOP_INSTR;
      // The in-flight response still has to be absorbed before refetching.
      if ((state == WAIT) && !imem.imem_rvalid) begin
        state_n = WAIT;
        drop_n  = 1'b1;
      end else begin
        state_n = FETCH;
        drop_n  = 1'b0;
      end
    end else begin
      case (state)
        FETCH: if (accepted) state_n = WAIT;
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = FETCH;
            end else begin
              word_n  = imem.imem_rdata;
              valid_n = 1'b1;
              state_n = VALID;
            end
          end
        end
        VALID: begin
          if (PCWrite) begin
            pc_n    = pc_inc;
            valid_n = 1'b0;
            word_n  = NOP_INSTR;
            state_n = accepted ? WAIT : FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      if_valid       <= 1'b0;
      if_instruction <= NOP_INSTR;
      if_pc_plus_4   <= RESET_PC + 32'd4;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      drop           <= drop_n;
      if_valid       <= valid_n;
      if_instruction <= word_n;
      if_pc_plus_4   <= pc_n + 32'd4;
    end
  end

  // The held word is always the one at pc, so the pc register doubles as if_pc.
  assign if_pc = pc;

endmodule
`default_nettype wire
